closest_hit_reduce: RTL

- Sits directly downstream of the triangle-intersection calculation pipeline.
- Consumes one intersection beat per cycle: sid, hit, t, intersection point, normal, and a last-triangle marker. The marker arrives aligned with the pipeline output.
- Per ray, keeps the nearest valid hit across all triangles tested. On the last beat it emits one resolved record into an output FIFO with a valid/ready handshake to the shading stage.
- The upstream pipeline cannot stall, so this block absorbs backpressure and flags any overflow.

---
 rtl/closest_hit_reduce_if.sv | 57 +++++
 rtl/closest_hit_reduce.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/closest_hit_reduce_if.sv
// ============================================================================
//  Module   : closest_hit_reduce_if
//  Purpose  : Bundles the intersection-beat input bus, the resolved-record
//             output handshake and the status flags of closest_hit_reduce.
//  Ports    : master - producer/consumer side (drives beats and out_ready)
//             slave  - reducer side (consumes beats, drives records/status)
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface closest_hit_reduce_if #(
   parameter int TRI_W      = 16,
   parameter int FIFO_DEPTH = 4
);
   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

   // intersection beat
   logic             in_valid;
   logic [31:0]      in_sid;
   logic [TRI_W-1:0] in_tri_id;
   logic             in_last;
   logic             in_hit;
   logic [31:0]      in_t;
   logic [95:0]      in_point;
   logic [95:0]      in_norm;

   // resolved record
   logic             out_valid;
   logic             out_ready;
   logic [31:0]      out_sid;
   logic [TRI_W-1:0] out_tri_id;
   logic             out_hit;
   logic [31:0]      out_t;
   logic [95:0]      out_point;
   logic [95:0]      out_norm;

   // status
   logic             busy;
   logic [CNT_W-1:0] fifo_count;
   logic             overflow;

   modport master (
      output in_valid, in_sid, in_tri_id, in_last, in_hit, in_t, in_point, in_norm,
      output out_ready,
      input  out_valid, out_sid, out_tri_id, out_hit, out_t, out_point, out_norm,
      input  busy, fifo_count, overflow
   );

   modport slave (
      input  in_valid, in_sid, in_tri_id, in_last, in_hit, in_t, in_point, in_norm,
      input  out_ready,
      output out_valid, out_sid, out_tri_id, out_hit, out_t, out_point, out_norm,
      output busy, fifo_count, overflow
   );
endinterface

`default_nettype wire

// File: rtl/closest_hit_reduce.sv
// ============================================================================
//  Module   : closest_hit_reduce
//  Purpose  : Per-ray nearest-hit reduction behind the triangle-intersection
//             pipeline. Tracks the closest valid hit over all beats of a ray
//             and pushes one resolved record per ray into an output FIFO.
//  Ports    : clk  - clock
//             rst  - asynchronous active-low reset
//             bus  - closest_hit_reduce_if.slave (beats in, records out,
//                    busy / fifo_count / sticky overflow)
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module closest_hit_reduce #(
   parameter int          TRI_W      = 16,
   parameter int          FIFO_DEPTH = 4,
   parameter logic [31:0] T_MIN      = 32'h3A83126F
) (
   input  logic                 clk,
   input  logic                 rst,
   closest_hit_reduce_if.slave  bus
);
   localparam int          PTR_W = $clog2(FIFO_DEPTH);
   localparam int          CNT_W = $clog2(FIFO_DEPTH) + 1;
   localparam logic [31:0] T_INF = 32'h7F800000;

   localparam logic [0:0] S_IDLE  = 1'b0;
   localparam logic [0:0] S_ACCUM = 1'b1;

   typedef struct packed {
      logic [31:0]      sid;
      logic [TRI_W-1:0] tri_id;
      logic             hit;
      logic [31:0]      t;
      logic [95:0]      point;
      logic [95:0]      norm;
   } rec_t;

   logic [0:0]       state, state_nxt;
   rec_t             best, best_nxt, beat_rec, merged, push_data, head;
   logic             cand, take, mismatch;
   logic             push_req, push_ok, drop_second, best_load;
   logic             pop, full;
   rec_t             mem [FIFO_DEPTH];
   logic [PTR_W-1:0] rd_ptr, wr_ptr;
   logic [CNT_W-1:0] count;
   logic             overflow_r;

   // ---------------------------------------------------------------- beat
   // A non-candidate beat is normalised to the no-hit record so that the
   // held best can always be compared by magnitude (+Inf loses to any
   // candidate, because candidates never carry an all-ones exponent).
   always_comb begin
      cand = bus.in_hit && !bus.in_t[31] && (bus.in_t[30:23] != 8'hFF) &&
             (bus.in_t > T_MIN);
      beat_rec.sid    = bus.in_sid;
      beat_rec.hit    = cand;
      beat_rec.tri_id = cand ? bus.in_tri_id : '0;
      beat_rec.t      = cand ? bus.in_t : T_INF;
      beat_rec.point  = cand ? bus.in_point : '0;
      beat_rec.norm   = cand ? bus.in_norm : '0;
      // strictly smaller wins: ties keep the earlier triangle
      take     = cand && (bus.in_t[30:0] < best.t[30:0]);
      merged   = take ? beat_rec : best;
      mismatch = (state == S_ACCUM) && (bus.in_sid != best.sid);
   end

   // ---------------------------------------------------------------- datapath control
   always_comb begin
      push_req    = 1'b0;
      push_data   = beat_rec;
      drop_second = 1'b0;
      best_load   = 1'b0;
      best_nxt    = beat_rec;
      if (bus.in_valid) begin
         if (state == S_IDLE) begin
            if (bus.in_last) push_req  = 1'b1;
            else             best_load = 1'b1;
         end else if (mismatch) begin
            // held ray closes; the new beat starts a fresh ray. Only one
            // record can be pushed per cycle, so a last new beat is lost.
            push_req  = 1'b1;
            push_data = best;
            if (bus.in_last) drop_second = 1'b1;
            else             best_load   = 1'b1;
         end else begin
            if (bus.in_last) begin
               push_req  = 1'b1;
               push_data = merged;
            end else begin
               best_load = 1'b1;
               best_nxt  = merged;
            end
         end
      end
   end

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= S_IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (bus.in_valid && !bus.in_last) state_nxt = S_ACCUM;
         S_ACCUM: if (bus.in_valid &&  bus.in_last) state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      bus.busy = (state == S_ACCUM);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)           best <= '0;
      else if (best_load) best <= best_nxt;
   end

   // ---------------------------------------------------------------- FIFO
   always_comb begin
      full    = (count == CNT_W'(FIFO_DEPTH));
      pop     = (count != '0) && bus.out_ready;
      // when full, a simultaneous pop frees the slot being written
      push_ok = push_req && (!full || pop);
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= push_data;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_ptr     <= '0;
         wr_ptr     <= '0;
         count      <= '0;
         overflow_r <= 1'b0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push_ok, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
         if ((push_req && !push_ok) || drop_second) overflow_r <= 1'b1;
      end
   end

   // data outputs read as zero whenever the FIFO is empty
   always_comb begin
      head           = (count != '0) ? mem[rd_ptr] : '0;
      bus.out_valid  = (count != '0);
      bus.out_sid    = head.sid;
      bus.out_tri_id = head.tri_id;
      bus.out_hit    = head.hit;
      bus.out_t      = head.t;
      bus.out_point  = head.point;
      bus.out_norm   = head.norm;
      bus.fifo_count = count;
      bus.overflow   = overflow_r;
   end

endmodule

`default_nettype wire
